// File: rtl/wm8731_cfg_ctrl.sv
// WM8731 configuration sequencer: writes the fixed register table over the 2-wire control
// port after power-up, then services headphone-volume updates, retrying NACKed frames.
module wm8731_cfg_ctrl #(
  parameter int unsigned QDIV       = 125,
  parameter int unsigned PWRUP_WAIT = 50000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A
) (
  input  logic       clock_50M,
  input  logic       reset_n,
  input  logic       cfg_start,
  input  logic       vol_req,
  input  logic [6:0] vol_val,
  output logic       i2c_scl,
  output logic       i2c_sda_oe,
  input  logic       i2c_sda_in,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int unsigned WW = $clog2(PWRUP_WAIT + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    StWaitPwr, StIdle, StStart, StByte, StAck, StStop, StGap
  } state_e;

  state_e          r_state, w_state;
  logic [1:0]      r_phase, w_phase;
  logic [2:0]      r_bit, w_bit;
  logic [1:0]      r_byte, w_byte;
  logic [2:0]      r_idx, w_idx;
  logic [RW-1:0]   r_retry, w_retry;
  logic            r_nack, w_nack;
  logic            r_vol_mode, w_vol_mode;
  logic            r_cfg_done, w_cfg_done;
  logic            r_cfg_err, w_cfg_err;
  logic [WW-1:0]   r_wcnt, w_wcnt;
  logic [QW-1:0]   r_qcnt;
  logic            r_vol_pend;
  logic [6:0]      r_vol_val, r_vol_frame;
  logic            w_tick, w_vol_take;
  logic [15:0]     w_entry;
  logic [6:0]      w_reg;
  logic [8:0]      w_data;
  logic [7:0]      w_cur;

  function automatic logic [15:0] table_entry(input logic [2:0] idx);
    logic [15:0] e;
    unique case (idx)
      3'd0:    e = {7'd15, 9'h000};
      3'd1:    e = {7'd6,  9'h000};
      3'd2:    e = {7'd4,  9'h012};
      3'd3:    e = {7'd5,  9'h000};
      3'd4:    e = {7'd7,  9'h00E};
      3'd5:    e = {7'd8,  9'h000};
      3'd6:    e = {7'd2,  9'h179};
      default: e = {7'd9,  9'h001};
    endcase
    return e;
  endfunction

  assign w_tick = (r_qcnt == QW'(QDIV - 1));

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) r_qcnt <= '0;
    else          r_qcnt <= w_tick ? '0 : r_qcnt + 1'b1;
  end

  // Volume is captured as the START condition ends, so requests up to that point coalesce.
  assign w_vol_take = (r_state == StStart) && w_tick && (r_phase == 2'd2) && r_vol_mode &&
                      r_vol_pend;

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_vol_pend  <= 1'b0;
      r_vol_val   <= '0;
      r_vol_frame <= '0;
    end else begin
      if (vol_req) r_vol_val <= vol_val;
      if (w_vol_take) r_vol_frame <= vol_req ? vol_val : r_vol_val;
      if (vol_req)         r_vol_pend <= 1'b1;
      else if (w_vol_take) r_vol_pend <= 1'b0;
    end
  end

  assign w_entry = table_entry(r_idx);
  assign w_reg   = r_vol_mode ? 7'd2 : w_entry[15:9];
  assign w_data  = r_vol_mode ? {2'b10, r_vol_frame} : w_entry[8:0];

  always_comb begin
    case (r_byte)
      2'd0:    w_cur = {DEV_ADDR, 1'b0};
      2'd1:    w_cur = {w_reg, w_data[8]};
      default: w_cur = w_data[7:0];
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_phase    = r_phase;
    w_bit      = r_bit;
    w_byte     = r_byte;
    w_idx      = r_idx;
    w_retry    = r_retry;
    w_nack     = r_nack;
    w_vol_mode = r_vol_mode;
    w_cfg_done = r_cfg_done;
    w_cfg_err  = r_cfg_err;
    w_wcnt     = r_wcnt;
    unique case (r_state)
      StWaitPwr: begin
        w_wcnt = r_wcnt + 1'b1;
        if (r_wcnt == WW'(PWRUP_WAIT - 1)) begin
          w_state    = StStart;
          w_phase    = '0;
          w_idx      = '0;
          w_vol_mode = 1'b0;
        end
      end
      StIdle: begin
        if (cfg_start) begin
          w_cfg_done = 1'b0;
          w_cfg_err  = 1'b0;
          w_retry    = '0;
          w_idx      = '0;
          w_vol_mode = 1'b0;
          w_phase    = '0;
          w_state    = StStart;
        end else if (r_cfg_done && r_vol_pend) begin
          w_vol_mode = 1'b1;
          w_retry    = '0;
          w_phase    = '0;
          w_state    = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          if (r_phase == 2'd2) begin
            w_phase = '0;
            w_bit   = 3'd7;
            w_byte  = '0;
            w_nack  = 1'b0;
            w_state = StByte;
          end else begin
            w_phase = r_phase + 2'd1;
          end
        end
      end
      StByte: begin
        if (w_tick) begin
          w_phase = r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (r_bit == 3'd0) w_state = StAck;
            else               w_bit   = r_bit - 3'd1;
          end
        end
      end
      StAck: begin
        if (w_tick) begin
          w_phase = r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (i2c_sda_in) begin
              w_nack  = 1'b1;
              w_state = StStop;
            end else if (r_byte == 2'd2) begin
              w_state = StStop;
            end else begin
              w_byte  = r_byte + 2'd1;
              w_bit   = 3'd7;
              w_state = StByte;
            end
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          if (r_phase == 2'd2) begin
            w_phase = '0;
            if (r_nack) begin
              w_retry = r_retry + 1'b1;
              if (r_retry == RW'(MAX_RETRY)) begin
                w_cfg_err = 1'b1;
                w_state   = StIdle;
              end else begin
                w_state = StGap;
              end
            end else begin
              w_retry = '0;
              if (r_vol_mode) begin
                w_state = StIdle;
              end else if (r_idx == 3'd7) begin
                w_cfg_done = 1'b1;
                w_state    = StIdle;
              end else begin
                w_idx   = r_idx + 3'd1;
                w_state = StGap;
              end
            end
          end else begin
            w_phase = r_phase + 2'd1;
          end
        end
      end
      StGap: begin
        if (w_tick) begin
          w_phase = r_phase + 2'd1;
          if (r_phase == 2'd3) w_state = StStart;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StWaitPwr;
      r_phase    <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_nack     <= 1'b0;
      r_vol_mode <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_wcnt     <= '0;
    end else begin
      r_state    <= w_state;
      r_phase    <= w_phase;
      r_bit      <= w_bit;
      r_byte     <= w_byte;
      r_idx      <= w_idx;
      r_retry    <= w_retry;
      r_nack     <= w_nack;
      r_vol_mode <= w_vol_mode;
      r_cfg_done <= w_cfg_done;
      r_cfg_err  <= w_cfg_err;
      r_wcnt     <= w_wcnt;
    end
  end

  // Bus pins decode straight from state so a reset releases the bus immediately.
  always_comb begin
    i2c_scl    = 1'b1;
    i2c_sda_oe = 1'b0;
    case (r_state)
      StStart: begin
        i2c_scl    = (r_phase != 2'd2);
        i2c_sda_oe = (r_phase != 2'd0);
      end
      StByte: begin
        i2c_scl    = r_phase[1];
        i2c_sda_oe = ~w_cur[r_bit];
      end
      StAck:   i2c_scl = r_phase[1];
      StStop: begin
        i2c_scl    = (r_phase != 2'd0);
        i2c_sda_oe = (r_phase != 2'd2);
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != StIdle) && (r_state != StWaitPwr);
  assign cfg_done = r_cfg_done;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_wm8731_cfg_ctrl.sv
// Bench for wm8731_cfg_ctrl: a behavioural codec decodes bus frames (with optional NACKs) and
// each scenario compares the decoded frames against table/volume values built from arithmetic.
module tb_wm8731_cfg_ctrl;
  localparam int unsigned QDIV  = 4;
  localparam int unsigned PWRUP = 10;
  localparam int unsigned MAXR  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       vol_req = 1'b0;
  logic [6:0] vol_val = '0;
  logic       scl, sda_oe, busy, done, err;
  logic       slave_low = 1'b0;
  wire        sda_line = !(sda_oe || slave_low);

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wm8731_cfg_ctrl #(
    .QDIV      (QDIV),
    .PWRUP_WAIT(PWRUP),
    .MAX_RETRY (MAXR),
    .DEV_ADDR  (7'h1A)
  ) dut (
    .clock_50M (clk),
    .reset_n   (rst_n),
    .cfg_start (cfg_start),
    .vol_req   (vol_req),
    .vol_val   (vol_val),
    .i2c_scl   (scl),
    .i2c_sda_oe(sda_oe),
    .i2c_sda_in(sda_line),
    .busy      (busy),
    .cfg_done  (done),
    .cfg_err   (err)
  );

  typedef struct {
    int          n;
    logic [23:0] b;
  } frame_t;

  frame_t      frames[$];
  int          starts = 0;
  int          nack_mode = 0;  // 0 ack all, 1 nack byte1 of R4 once, 2 nack address always
  bit          nacked_once = 0;
  logic        pscl = 1'b1, psda = 1'b1;
  int          bitcnt = 0, nb = 0;
  bit          ack_ph = 0, in_frame = 0, nk;
  logic [7:0]  sh = '0;
  logic [23:0] cur = '0;

  int tbl_reg[8] = '{15, 6, 4, 5, 7, 8, 2, 9};
  int tbl_dat[8] = '{'h000, 'h000, 'h012, 'h000, 'h00E, 'h000, 'h179, 'h001};

  // Codec model: watches the bus away from the active edge and answers ACK slots.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; slave_low = 1'b0; bitcnt = 0; nb = 0; ack_ph = 0; pscl = 1'b1; psda = 1'b1;
    end else begin
      if (scl && pscl && psda && !sda_line) begin
        in_frame = 1; bitcnt = 0; nb = 0; ack_ph = 0; cur = '0; starts++;
      end else if (scl && pscl && !psda && sda_line) begin
        if (in_frame) frames.push_back('{nb, cur});
        in_frame = 0;
      end else if (!pscl && scl) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda_line};
          bitcnt++;
        end
      end else if (pscl && !scl && in_frame) begin
        if (ack_ph) begin
          slave_low = 1'b0; ack_ph = 0; bitcnt = 0; nb++;
        end else if (bitcnt == 8) begin
          if (nb < 3) cur[23-8*nb -: 8] = sh;
          nk = 0;
          if (nack_mode == 2 && nb == 0) nk = 1;
          if (nack_mode == 1 && nb == 1 && sh == 8'h08 && !nacked_once) begin
            nk = 1; nacked_once = 1;
          end
          ack_ph = 1;
          slave_low = !nk;
        end
      end
      pscl = scl;
      psda = !(sda_oe || slave_low);
    end
  end

  function automatic logic [23:0] exp_frame(input int r, input int d);
    logic [7:0] b1, b2;
    b1 = 8'((r * 2) + (d / 256));
    b2 = 8'(d % 256);
    return {8'h34, b1, b2};
  endfunction

  function automatic logic [23:0] got_b(input int i);
    return (i < frames.size()) ? frames[i].b : 24'hxxxxxx;
  endfunction

  function automatic int got_n(input int i);
    return (i < frames.size()) ? frames[i].n : -1;
  endfunction

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_vol(input logic [6:0] v);
    vol_val = v;
    vol_req = 1'b1;
    @(negedge clk);
    vol_req = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok, output bit fell_same);
    logic pb;
    ok = 0;
    fell_same = 0;
    for (int i = 0; i < max; i++) begin
      pb = busy;
      @(negedge clk);
      if (done) begin
        ok = 1;
        fell_same = (pb === 1'b1) && (busy === 1'b0);
        break;
      end
    end
  endtask

  task automatic wait_frames(input int cnt, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frames.size() >= cnt && !busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  cyc;
    bit  seen;
    logic busy_wait;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b want 1", scl); end
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    frames.delete();
    starts = 0;
    seen = 0;
    cyc = 0;
    busy_wait = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) busy_wait = busy;
      if (starts > 0) begin seen = 1; break; end
    end
    n_tests++; if (busy_wait !== 1'b0) begin n_fail++; $display("FAIL pwr_busy: got %b want 0", busy_wait); end
    n_tests++;
    if (!seen || cyc < int'(PWRUP) || cyc > int'(PWRUP + 3 * QDIV)) begin
      n_fail++; $display("FAIL pwr_wait: got %0d cycles want %0d..%0d", cyc, PWRUP, PWRUP + 3 * QDIV);
    end
  endtask

  task automatic test_table();
    bit ok, fell;
    wait_done(10000, ok, fell);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL table_done: got timeout want cfg_done"); end
    n_tests++; if (!fell) begin n_fail++; $display("FAIL table_busy_fall: got 0 want busy 1->0 with done"); end
    n_tests++; if (frames.size() != 8) begin n_fail++; $display("FAIL table_count: got %0d want 8", frames.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_n(i) != 3 || got_b(i) !== exp_frame(tbl_reg[i], tbl_dat[i])) begin
        n_fail++;
        $display("FAIL table_frame%0d: got n=%0d %h want n=3 %h", i, got_n(i), got_b(i),
                 exp_frame(tbl_reg[i], tbl_dat[i]));
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL table_err: got %b want 0", err); end
  endtask

  task automatic test_nack_retry();
    bit ok, fell;
    int k;
    nack_mode = 1;
    nacked_once = 0;
    frames.delete();
    pulse_start();
    repeat ($urandom_range(200, 1500)) @(negedge clk);
    pulse_start();
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL start_busy_ignored: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(10000, ok, fell);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nack_done: got timeout want cfg_done"); end
    n_tests++; if (frames.size() != 9) begin n_fail++; $display("FAIL nack_count: got %0d want 9", frames.size()); end
    n_tests++;
    if (got_n(2) != 2 || got_b(2) !== {exp_frame(4, 'h012)[23:8], 8'h00}) begin
      n_fail++; $display("FAIL nack_partial: got n=%0d %h want n=2 %h", got_n(2), got_b(2),
                         {exp_frame(4, 'h012)[23:8], 8'h00});
    end
    for (int i = 0; i < 8; i++) begin
      k = (i < 2) ? i : i + 1;
      n_tests++;
      if (got_n(k) != 3 || got_b(k) !== exp_frame(tbl_reg[i], tbl_dat[i])) begin
        n_fail++; $display("FAIL nack_frame%0d: got n=%0d %h want n=3 %h", k, got_n(k), got_b(k),
                           exp_frame(tbl_reg[i], tbl_dat[i]));
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL nack_err: got %b want 0", err); end
    nack_mode = 0;
  endtask

  task automatic test_nack_exhaust();
    bit ok;
    nack_mode = 2;
    frames.delete();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (err) begin ok = 1; break; end
    end
    repeat (700) @(negedge clk);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL exh_err: got timeout want cfg_err"); end
    n_tests++; if (frames.size() != int'(MAXR + 1)) begin
      n_fail++; $display("FAIL exh_attempts: got %0d want %0d", frames.size(), MAXR + 1);
    end
    for (int i = 0; i < int'(MAXR + 1); i++) begin
      n_tests++;
      if (got_n(i) != 1 || got_b(i)[23:16] !== 8'h34) begin
        n_fail++; $display("FAIL exh_frame%0d: got n=%0d %h want n=1 addr 34", i, got_n(i), got_b(i));
      end
    end
    n_tests++;
    if ({err, done, busy, scl, sda_oe} !== 5'b10010) begin
      n_fail++; $display("FAIL exh_state: got err,done,busy,scl,oe=%b want 10010",
                         {err, done, busy, scl, sda_oe});
    end
    nack_mode = 0;
  endtask

  task automatic test_restart_after_err();
    bit ok, fell, seen;
    int s0;
    frames.delete();
    s0 = starts;
    pulse_start();
    n_tests++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_flags: got err=%b busy=%b want 0/1", err, busy);
    end
    seen = 0;
    for (int i = 0; i < int'(2 * QDIV); i++) begin
      if (starts != s0) begin seen = 1; break; end
      @(negedge clk);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL restart_latency: got no START want within one tick"); end
    wait_done(10000, ok, fell);
    n_tests++; if (!ok || frames.size() != 8) begin
      n_fail++; $display("FAIL restart_count: got done=%b n=%0d want 1/8", ok, frames.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_b(i) !== exp_frame(tbl_reg[i], tbl_dat[i])) begin
        n_fail++; $display("FAIL restart_frame%0d: got %h want %h", i, got_b(i),
                           exp_frame(tbl_reg[i], tbl_dat[i]));
      end
    end
  endtask

  task automatic test_volume();
    bit ok;
    logic [6:0] v;
    frames.delete();
    pulse_vol(7'h50);
    pulse_vol(7'h30);
    wait_frames(1, 2000, ok);
    repeat (700) @(negedge clk);
    n_tests++; if (!ok || frames.size() != 1) begin
      n_fail++; $display("FAIL vol_coalesce: got %0d frames want 1", frames.size());
    end
    n_tests++; if (got_b(0) !== exp_frame(2, 'h130)) begin
      n_fail++; $display("FAIL vol_value: got %h want %h", got_b(0), exp_frame(2, 'h130));
    end
    for (int r = 0; r < 3; r++) begin
      v = 7'($urandom_range(0, 127));
      frames.delete();
      pulse_vol(v);
      wait_frames(1, 2000, ok);
      n_tests++;
      if (!ok || got_b(0) !== exp_frame(2, 256 + int'(v)) || done !== 1'b1) begin
        n_fail++; $display("FAIL vol_rand%0d: got %h done=%b want %h done=1", r, got_b(0), done,
                           exp_frame(2, 256 + int'(v)));
      end
    end
  endtask

  task automatic test_vol_pending();
    bit ok, fell;
    logic [6:0] v;
    v = 7'($urandom_range(0, 127));
    frames.delete();
    vol_val = v;
    vol_req = 1'b1;
    cfg_start = 1'b1;
    @(negedge clk);
    vol_req = 1'b0;
    cfg_start = 1'b0;
    n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pend_start: got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(10000, ok, fell);
    wait_frames(9, 2000, ok);
    repeat (300) @(negedge clk);
    n_tests++; if (frames.size() != 9) begin n_fail++; $display("FAIL pend_count: got %0d want 9", frames.size()); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_b(i) !== exp_frame(tbl_reg[i], tbl_dat[i])) begin
        n_fail++; $display("FAIL pend_frame%0d: got %h want %h", i, got_b(i),
                           exp_frame(tbl_reg[i], tbl_dat[i]));
      end
    end
    n_tests++; if (got_b(8) !== exp_frame(2, 256 + int'(v))) begin
      n_fail++; $display("FAIL pend_vol: got %h want %h", got_b(8), exp_frame(2, 256 + int'(v)));
    end
  endtask

  task automatic test_reset_mid();
    bit ok, fell, seen;
    int k, cyc, s0;
    k = $urandom_range(1, 6);
    frames.delete();
    pulse_vol(7'($urandom_range(0, 127)));
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_frame && nb == 1 && bitcnt >= k) begin seen = 1; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_reach_byte1: got timeout want byte1"); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({scl, sda_oe, busy, done} !== 4'b1000) begin
      n_fail++; $display("FAIL mid_reset_out: got scl,oe,busy,done=%b want 1000", {scl, sda_oe, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames.delete();
    s0 = starts;
    cyc = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (starts != s0) begin seen = 1; break; end
    end
    n_tests++; if (!seen || cyc < int'(PWRUP)) begin
      n_fail++; $display("FAIL mid_pwr_wait: got %0d cycles want >= %0d", cyc, PWRUP);
    end
    wait_done(10000, ok, fell);
    repeat (700) @(negedge clk);
    n_tests++; if (!ok || frames.size() != 8) begin
      n_fail++; $display("FAIL mid_count: got done=%b n=%0d want 1/8", ok, frames.size());
    end
    n_tests++; if (got_b(0) !== exp_frame(tbl_reg[0], tbl_dat[0]) || got_b(7) !== exp_frame(tbl_reg[7], tbl_dat[7])) begin
      n_fail++; $display("FAIL mid_frames: got %h/%h want %h/%h", got_b(0), got_b(7),
                         exp_frame(tbl_reg[0], tbl_dat[0]), exp_frame(tbl_reg[7], tbl_dat[7]));
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_nack_retry();
    test_nack_exhaust();
    test_restart_after_err();
    test_volume();
    test_vol_pending();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wm8731_cfg_ctrl.md
Name: wm8731_cfg_ctrl

Overview:
- Configuration sequencer for the WM8731 codec, sitting beside the DAC serializer in the audio path.
- After reset it writes a fixed 8-entry register table over the codec's 2-wire (I2C-style) control port.
- It raises cfg_done, which the parent uses to gate play_en into the serializer.
- After configuration it accepts runtime headphone-volume updates. It retries NACKed writes and flags a persistent failure.

Parameters:
- QDIV, 125, clock_50M cycles per SCL quarter-period (50 MHz / (4*125) = 100 kHz SCL)
- PWRUP_WAIT, 50000, cycles between reset release and first transaction (1 ms)
- MAX_RETRY, 3, retries per entry after a NACK before declaring error
- DEV_ADDR, 7'h1A, codec 7-bit bus address (CSB low)

Ports:
- clock_50M  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse: re-run full table (ignored while busy)
- vol_req  in  1  one-cycle pulse: write headphone volume
- vol_val  in  7  headphone volume code (0x79 = 0 dB)
- i2c_scl  out  1  serial clock, push-pull
- i2c_sda_oe  out  1  1 = drive SDA low, 0 = release (external pull-up)
- i2c_sda_in  in  1  sampled SDA line
- busy  out  1  transaction sequence in progress
- cfg_done  out  1  table written successfully; held until next cfg_start or reset
- cfg_err  out  1  retries exhausted; sticky until cfg_start or reset

Behaviour:
- Reset (async, reset_n=0): i2c_scl=1, i2c_sda_oe=0, busy=0, cfg_done=0, cfg_err=0. Table index, retry count, quarter counter and pending-volume flag all cleared. FSM goes to WAIT_PWR.
- Reset asserted mid-frame aborts immediately. The bus is left idle (SCL=1, SDA released) with no STOP.
- Quarter tick: a free-running counter of 0..QDIV-1 pulses a tick at QDIV-1. Every FSM bit-phase advance happens only on a tick.
- Bit timing per data/ACK bit, 4 ticks: Q0 SCL=0, set SDA; Q1 SCL=0; Q2 SCL=1; Q3 SCL=1, sample i2c_sda_in.
- START: SDA released with SCL=1 for 1 tick, then SDA low for 1 tick, then SCL low.
- STOP: SCL=0/SDA low, then SCL=1, then SDA released, 1 tick each.
- Frame = START, byte0 {DEV_ADDR,0}, ACK, byte1 {reg[6:0],data[8]}, ACK, byte2 data[7:0], ACK, STOP. Bytes are sent MSB first. During ACK slots i2c_sda_oe=0.
- ACK check: sampled 0 = ACK, 1 = NACK.
  - On NACK: go to STOP, increment retry, and resend the same frame.
  - If retry > MAX_RETRY: cfg_err=1, busy=0, FSM goes to IDLE, cfg_done stays 0.
  - The retry count clears on each successful frame.
- GAP: 4 ticks of idle bus between frames.
- FSM states: WAIT_PWR, IDLE, START, BYTE, ACK, STOP, GAP.
  - WAIT_PWR counts PWRUP_WAIT cycles, then moves to START with index 0.
  - After the STOP of entry 7 succeeds: cfg_done=1, busy=0, go to IDLE.
- Table (reg, 9-bit data), fixed order:
  - 0: R15 0x000 (reset)
  - 1: R6 0x000 (power all on)
  - 2: R4 0x012 (DAC select, mic mute)
  - 3: R5 0x000
  - 4: R7 0x00E (I2S, 32-bit, slave)
  - 5: R8 0x000 (normal, 48 kHz)
  - 6: R2 0x179 (both channels, 0 dB)
  - 7: R9 0x001 (active)
- busy=1 from WAIT_PWR exit until return to IDLE.
- Volume update:
  - vol_req latches vol_val and sets a pending flag, at any time. The latest value wins.
  - In IDLE with cfg_done=1 and pending set, the block sends one frame R2 = {1'b1, 1'b0, vol}, then clears pending.
  - vol_req while cfg_done=0 stays pending until configuration completes.
  - Same NACK/retry rules apply. Exhausted retries set cfg_err, and cfg_done stays 1.
- cfg_start in IDLE: clears cfg_done, cfg_err, retry and index, then goes directly to START (no power-up wait).
  - cfg_start while busy is ignored.
  - cfg_start and vol_req in the same cycle: the table runs first and the volume write stays pending.

Test Plan:
- Reset release, codec model ACKs all bytes, QDIV=4, PWRUP_WAIT=10 -> 8 frames decoded as (0x0F,0x000),(0x06,0x000),(0x04,0x012),(0x05,0x000),(0x07,0x00E),(0x08,0x000),(0x02,0x179),(0x09,0x001), each with addr byte 0x34; cfg_done=1 after last STOP; busy falls the same cycle.
- Model NACKs byte1 of entry 2 once -> STOP, entry 2 resent identically, sequence completes, cfg_done=1, cfg_err=0.
- Model NACKs address byte always, MAX_RETRY=3 -> exactly 4 attempts of entry 0, then cfg_err=1, cfg_done=0, busy=0, bus idle.
- After cfg_done, vol_req with vol_val=0x50, then vol_req with 0x30 before the frame starts -> single frame R2 data 0x130.
- reset_n pulsed low mid byte1 -> outputs immediately SCL=1, sda_oe=0, busy=0, cfg_done=0; after release, full table restarts from entry 0 after PWRUP_WAIT.
- cfg_start pulsed while busy -> no effect; pulsed in IDLE after error -> cfg_err clears, table rerun starting within one tick.
